// File: rtl/reg_block_write_sequencer_pkg.sv
// Shared types and constants for the block-load register write sequencer.
package reg_block_write_sequencer_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_REQ,
    ST_WAIT,
    ST_WRITE,
    ST_DONE
  } state_e;

  localparam logic [3:0] REG_PC     = 4'd15;
  localparam int         WORD_BYTES = 4;

endpackage

// File: rtl/reg_block_write_sequencer_priority_encoder.sv
// Lowest-set-bit encoder over a 16-bit register list; picks the next register to load.
module reg_list_priority_encoder (
  input  logic [15:0] list_i,
  output logic [3:0]  index_o,
  output logic        nonzero_o
);

  // Scan from the top down so the lowest set bit wins.
  always_comb begin
    index_o = '0;
    for (int i = 15; i >= 0; i--) begin
      if (list_i[i]) index_o = 4'(i);
    end
  end

  assign nonzero_o = |list_i;

endmodule

// File: rtl/reg_block_write_sequencer.sv
// Block-load writer: fetches one word per listed register and drives the register file
// write port, redirecting R15 to a PC load.
module reg_block_write_sequencer
  import reg_block_write_sequencer_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [15:0]      reg_list,
  input  logic [WIDTH-1:0] base_addr,
  input  logic             up,
  output logic             mem_req_valid,
  input  logic             mem_req_ready,
  output logic [WIDTH-1:0] mem_addr,
  input  logic             mem_rsp_valid,
  input  logic [WIDTH-1:0] mem_rsp_data,
  output logic             rf_write_enable,
  output logic [3:0]       rf_dest_select,
  output logic [WIDTH-1:0] rf_data,
  output logic             pc_load,
  output logic [WIDTH-1:0] pc_value,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] wb_addr
);

  state_e           state_q, state_d;
  logic [15:0]      remList_q, remList_d;
  logic [WIDTH-1:0] addr_q, addr_d;
  logic [WIDTH-1:0] wbAddr_q, wbAddr_d;
  logic [WIDTH-1:0] word_q, word_d;
  logic [3:0]       dest_q, dest_d;

  logic [3:0]       lowIdx;
  logic             listNonzero;
  logic [4:0]       listCount;
  logic [WIDTH-1:0] blockBytes;

  reg_list_priority_encoder u_encoder (
    .list_i    (remList_q),
    .index_o   (lowIdx),
    .nonzero_o (listNonzero)
  );

  always_comb begin
    listCount = '0;
    for (int i = 0; i < 16; i++) begin
      listCount = listCount + 5'(reg_list[i]);
    end
  end

  assign blockBytes = WIDTH'(listCount) * WIDTH'(WORD_BYTES);

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q   <= ST_IDLE;
      remList_q <= '0;
      addr_q    <= '0;
      wbAddr_q  <= '0;
      word_q    <= '0;
      dest_q    <= '0;
    end else begin
      state_q   <= state_d;
      remList_q <= remList_d;
      addr_q    <= addr_d;
      wbAddr_q  <= wbAddr_d;
      word_q    <= word_d;
      dest_q    <= dest_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (start) state_d = (listCount != 5'd0) ? ST_REQ : ST_DONE;
      ST_REQ:   if (mem_req_ready) state_d = ST_WAIT;
      ST_WAIT:  if (mem_rsp_valid) state_d = ST_WRITE;
      ST_WRITE: state_d = listNonzero ? ST_REQ : ST_DONE;
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Descending loads still walk upward, starting N words below the base.
  always_comb begin
    remList_d = remList_q;
    addr_d    = addr_q;
    wbAddr_d  = wbAddr_q;
    word_d    = word_q;
    dest_d    = dest_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          remList_d = reg_list;
          addr_d    = up ? base_addr : base_addr - blockBytes;
          wbAddr_d  = up ? base_addr + blockBytes : base_addr - blockBytes;
        end
      end
      ST_REQ: begin
        if (mem_req_ready) addr_d = addr_q + WIDTH'(WORD_BYTES);
      end
      ST_WAIT: begin
        if (mem_rsp_valid) begin
          word_d    = mem_rsp_data;
          dest_d    = lowIdx;
          remList_d = remList_q & ~(16'd1 << lowIdx);
        end
      end
      default: ;
    endcase
  end

  always_comb begin
    mem_req_valid   = 1'b0;
    mem_addr        = '0;
    rf_write_enable = 1'b0;
    rf_dest_select  = '0;
    rf_data         = '0;
    pc_load         = 1'b0;
    pc_value        = '0;
    done            = 1'b0;
    busy            = (state_q != ST_IDLE);
    case (state_q)
      ST_REQ: begin
        mem_req_valid = 1'b1;
        mem_addr      = addr_q;
      end
      ST_WRITE: begin
        if (dest_q == REG_PC) begin
          pc_load  = 1'b1;
          pc_value = word_q;
        end else begin
          rf_write_enable = 1'b1;
          rf_dest_select  = dest_q;
          rf_data         = word_q;
        end
      end
      ST_DONE: done = 1'b1;
      default: ;
    endcase
  end

  assign wb_addr = wbAddr_q;

endmodule

// File: tb/tb_reg_block_write_sequencer.sv
// Self-checking bench: a transaction-level model predicts request addresses, register
// writes, PC loads and the write-back base; a memory responder supplies data with delays.
module tb_reg_block_write_sequencer;

  logic        clk;
  logic        reset;
  logic        start;
  logic [15:0] reg_list;
  logic [31:0] base_addr;
  logic        up;
  logic        mem_req_valid;
  logic        mem_req_ready;
  logic [31:0] mem_addr;
  logic        mem_rsp_valid;
  logic [31:0] mem_rsp_data;
  logic        rf_write_enable;
  logic [3:0]  rf_dest_select;
  logic [31:0] rf_data;
  logic        pc_load;
  logic [31:0] pc_value;
  logic        busy;
  logic        done;
  logic [31:0] wb_addr;

  reg_block_write_sequencer #(.WIDTH(32)) dut (
    .clk             (clk),
    .reset           (reset),
    .start           (start),
    .reg_list        (reg_list),
    .base_addr       (base_addr),
    .up              (up),
    .mem_req_valid   (mem_req_valid),
    .mem_req_ready   (mem_req_ready),
    .mem_addr        (mem_addr),
    .mem_rsp_valid   (mem_rsp_valid),
    .mem_rsp_data    (mem_rsp_data),
    .rf_write_enable (rf_write_enable),
    .rf_dest_select  (rf_dest_select),
    .rf_data         (rf_data),
    .pc_load         (pc_load),
    .pc_value        (pc_value),
    .busy            (busy),
    .done            (done),
    .wb_addr         (wb_addr)
  );

  int errors = 0;
  int checks = 0;
  int cycleCnt = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cycleCnt <= cycleCnt + 1;

  initial begin
    #400000;
    $display("[TB] FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic logic [31:0] memWord(input logic [31:0] a);
    return (a * 32'h9E3779B1) ^ 32'h00C0FFEE;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
    end
  endtask

  // Memory responder: ready after readyDelay REQ cycles, data rspDelay cycles after acceptance.
  int          readyDelay = 0;
  int          rspDelay = 0;
  bit          accNow;
  logic [31:0] accAddr;
  bit          pending = 1'b0;
  int          pendCnt = 0;
  logic [31:0] pendAddr;
  int          reqCycles = 0;

  initial begin
    mem_req_ready = 1'b0;
    mem_rsp_valid = 1'b0;
    mem_rsp_data  = 32'hDEADBEEF;
    forever begin
      @(negedge clk);
      accNow  = mem_req_valid && mem_req_ready;
      accAddr = mem_addr;
      @(posedge clk);
      #1;
      if (accNow) begin
        pending  = 1'b1;
        pendCnt  = rspDelay;
        pendAddr = accAddr;
      end
      mem_rsp_valid = 1'b0;
      mem_rsp_data  = 32'hDEADBEEF;
      if (pending) begin
        if (pendCnt == 0) begin
          mem_rsp_valid = 1'b1;
          mem_rsp_data  = memWord(pendAddr);
          pending       = 1'b0;
        end else begin
          pendCnt--;
        end
      end
      if (mem_req_valid) begin
        mem_req_ready = (reqCycles >= readyDelay);
        reqCycles++;
      end else begin
        mem_req_ready = 1'b0;
        reqCycles     = 0;
      end
    end
  end

  // Transaction-level model of one block load.
  logic [31:0] reqQ[$];
  int          wrIdxQ[$];
  logic [31:0] wrDataQ[$];
  logic [31:0] expWb = 32'h0;
  bit          expBusy = 1'b0;
  bit          expDone = 1'b0;
  bit          stallPrev = 1'b0;
  bit          wroteLast;
  bit          sawReq;
  logic [31:0] firstReqAddr;
  logic [31:0] lastPc;
  int          rfWrites = 0;
  int          pcLoads = 0;
  int          reqValidCycles = 0;

  task automatic buildModel();
    int          n;
    logic [31:0] a;
    n = 0;
    for (int i = 0; i < 16; i++) if (reg_list[i]) n++;
    a = up ? base_addr : base_addr - 32'(4 * n);
    expWb = up ? base_addr + 32'(4 * n) : base_addr - 32'(4 * n);
    for (int i = 0; i < 16; i++) begin
      if (reg_list[i]) begin
        reqQ.push_back(a);
        wrIdxQ.push_back(i);
        wrDataQ.push_back(memWord(a));
        a = a + 32'd4;
      end
    end
    rfWrites       = 0;
    pcLoads        = 0;
    reqValidCycles = 0;
    sawReq         = 1'b0;
    firstReqAddr   = 32'h0;
    lastPc         = 32'h0;
  endtask

  always @(negedge clk) begin
    wroteLast = 1'b0;
    checkOutput("busy", 32'(busy), 32'(expBusy));
    checkOutput("done", 32'(done), 32'(expDone));
    checkOutput("write_pc_overlap", 32'(rf_write_enable & pc_load), 32'd0);
    if (stallPrev) checkOutput("req_held", 32'(mem_req_valid), 32'd1);
    if (mem_req_valid) begin
      reqValidCycles++;
      if (!sawReq) firstReqAddr = mem_addr;
      sawReq = 1'b1;
      if (reqQ.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL req_unexpected: request at 0x%0h, required no request", mem_addr);
      end else begin
        checkOutput("req_addr", mem_addr, reqQ[0]);
        if (mem_req_ready) void'(reqQ.pop_front());
      end
    end
    stallPrev = mem_req_valid && !mem_req_ready;
    if (rf_write_enable) begin
      rfWrites++;
      if (wrIdxQ.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL rf_write_unexpected: write R%0d, required no write", rf_dest_select);
      end else begin
        checkOutput("rf_dest", 32'(rf_dest_select), 32'(wrIdxQ[0]));
        checkOutput("rf_data", rf_data, wrDataQ[0]);
        void'(wrIdxQ.pop_front());
        void'(wrDataQ.pop_front());
        wroteLast = (wrIdxQ.size() == 0);
      end
    end
    if (pc_load) begin
      pcLoads++;
      lastPc = pc_value;
      if (wrIdxQ.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL pc_load_unexpected: pc_value 0x%0h, required no load", pc_value);
      end else begin
        checkOutput("pc_dest_is_r15", 32'(wrIdxQ[0]), 32'd15);
        checkOutput("pc_value", pc_value, wrDataQ[0]);
        void'(wrIdxQ.pop_front());
        void'(wrDataQ.pop_front());
        wroteLast = (wrIdxQ.size() == 0);
      end
    end
    if (done) checkOutput("wb_addr", wb_addr, expWb);

    if (!reset) begin
      reqQ.delete();
      wrIdxQ.delete();
      wrDataQ.delete();
      expBusy   = 1'b0;
      expDone   = 1'b0;
      stallPrev = 1'b0;
    end else if (expDone) begin
      expBusy = 1'b0;
      expDone = 1'b0;
    end else if (!expBusy && start) begin
      buildModel();
      expBusy = 1'b1;
      expDone = (wrIdxQ.size() == 0);
    end else begin
      expDone = wroteLast;
    end
  end

  task automatic applyStimulus(input logic [15:0] list, input logic [31:0] base,
                               input logic upv, output int startCyc);
    @(posedge clk);
    #1;
    start     = 1'b1;
    reg_list  = list;
    base_addr = base;
    up        = upv;
    startCyc  = cycleCnt;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic waitDone(input int budget, output int doneCyc, output int busyCyc);
    doneCyc = -1;
    busyCyc = 0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (busy) busyCyc++;
      if (done) begin
        doneCyc = cycleCnt;
        break;
      end
    end
    if (doneCyc < 0) begin
      checks++;
      errors++;
      $display("[TB] FAIL done_timeout: no done within %0d cycles, required done", budget);
    end
  endtask

  int startCyc;
  int doneCyc;
  int busyCyc;
  int rspSeen;
  int stray;

  initial begin
    reset     = 1'b0;
    start     = 1'b0;
    reg_list  = 16'h0;
    base_addr = 32'h0;
    up        = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b1;
    @(negedge clk);
    checkOutput("reset_busy", 32'(busy), 32'd0);
    checkOutput("reset_req_valid", 32'(mem_req_valid), 32'd0);
    checkOutput("reset_wb_addr", wb_addr, 32'd0);

    // Ascending three-word load with zero-wait memory.
    applyStimulus(16'h0013, 32'h100, 1'b1, startCyc);
    waitDone(200, doneCyc, busyCyc);
    checkOutput("t1_latency", 32'(doneCyc - startCyc), 32'd10);
    checkOutput("t1_busy_cycles", 32'(busyCyc), 32'd10);
    checkOutput("t1_wb_addr", wb_addr, 32'h10C);
    checkOutput("t1_first_req", firstReqAddr, 32'h100);
    checkOutput("t1_rf_writes", 32'(rfWrites), 32'd3);
    checkOutput("t1_pc_loads", 32'(pcLoads), 32'd0);

    // Descending load ending in R15.
    applyStimulus(16'h8002, 32'h200, 1'b0, startCyc);
    waitDone(200, doneCyc, busyCyc);
    checkOutput("t2_latency", 32'(doneCyc - startCyc), 32'd7);
    checkOutput("t2_wb_addr", wb_addr, 32'h1F8);
    checkOutput("t2_first_req", firstReqAddr, 32'h1F8);
    checkOutput("t2_rf_writes", 32'(rfWrites), 32'd1);
    checkOutput("t2_pc_loads", 32'(pcLoads), 32'd1);
    checkOutput("t2_pc_value", lastPc, memWord(32'h1FC));

    // Empty list.
    applyStimulus(16'h0000, 32'h400, 1'b1, startCyc);
    waitDone(50, doneCyc, busyCyc);
    checkOutput("t3_latency", 32'(doneCyc - startCyc), 32'd1);
    checkOutput("t3_busy_cycles", 32'(busyCyc), 32'd1);
    checkOutput("t3_req_cycles", 32'(reqValidCycles), 32'd0);
    checkOutput("t3_wb_addr", wb_addr, 32'h400);

    // Slow memory, with start pulses while busy.
    readyDelay = 5;
    rspDelay   = 3;
    applyStimulus(16'h0005, 32'h80, 1'b1, startCyc);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      start    = 1'b1;
      reg_list = 16'hFFFF;
    end
    @(posedge clk);
    #1;
    start = 1'b0;
    waitDone(400, doneCyc, busyCyc);
    checkOutput("t4_latency", 32'(doneCyc - startCyc), 32'd23);
    checkOutput("t4_rf_writes", 32'(rfWrites), 32'd2);
    checkOutput("t4_req_cycles", 32'(reqValidCycles), 32'd12);
    checkOutput("t4_wb_addr", wb_addr, 32'h88);

    // Reset while waiting for the response; the late response must be ignored.
    readyDelay = 0;
    rspDelay   = 3;
    applyStimulus(16'h0003, 32'h300, 1'b1, startCyc);
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b1;
    @(negedge clk);
    checkOutput("t5_busy", 32'(busy), 32'd0);
    checkOutput("t5_req_valid", 32'(mem_req_valid), 32'd0);
    checkOutput("t5_mem_addr", mem_addr, 32'd0);
    checkOutput("t5_wb_addr", wb_addr, 32'd0);
    rspSeen = 0;
    stray   = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (mem_rsp_valid) rspSeen++;
      if (rf_write_enable || pc_load || mem_req_valid || done) stray++;
    end
    checkOutput("t5_late_rsp_seen", 32'(rspSeen), 32'd1);
    checkOutput("t5_no_activity", 32'(stray), 32'd0);

    rspDelay = 0;
    applyStimulus(16'h0410, 32'h1000, 1'b0, startCyc);
    waitDone(200, doneCyc, busyCyc);
    checkOutput("t5_restart_latency", 32'(doneCyc - startCyc), 32'd7);
    checkOutput("t5_restart_writes", 32'(rfWrites), 32'd2);
    checkOutput("t5_restart_wb", wb_addr, 32'hFF8);

    // Full list with address wrap-around.
    applyStimulus(16'hFFFF, 32'hFFFFFFF8, 1'b1, startCyc);
    waitDone(400, doneCyc, busyCyc);
    checkOutput("t6_latency", 32'(doneCyc - startCyc), 32'd49);
    checkOutput("t6_rf_writes", 32'(rfWrites), 32'd15);
    checkOutput("t6_pc_loads", 32'(pcLoads), 32'd1);
    checkOutput("t6_wb_addr", wb_addr, 32'h38);
    checkOutput("t6_first_req", firstReqAddr, 32'hFFFFFFF8);

    repeat (3) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/reg_block_write_sequencer.md
Name: reg_block_write_sequencer

Overview:
Writer side of the processor register file: executes block loads (LDM/POP-style) by fetching one word per set bit of a 16-bit register list from data memory, then driving the register file write port (destination select, data, write enable) once per word. Writes targeting R15 do not go to the register file; they are redirected to a PC-load output. Sits between the execute/memory stages and the register file write port, and holds the pipeline stalled via busy while active.

Parameters:
WIDTH, 32, data and address width in bits.

Ports:
clk  input  1  system clock, all state updates on rising edge.
reset  input  1  synchronous, active-low reset.
start  input  1  begin transfer; sampled only in IDLE.
reg_list  input  16  bit i set = load Ri; sampled with start.
base_addr  input  WIDTH  base address; sampled with start.
up  input  1  1 = ascending from base, 0 = descending below base; sampled with start.
mem_req_valid  output  1  read request valid.
mem_req_ready  input  1  memory accepts request.
mem_addr  output  WIDTH  request address.
mem_rsp_valid  input  1  read data valid.
mem_rsp_data  input  WIDTH  read data.
rf_write_enable  output  1  register file write strobe.
rf_dest_select  output  4  destination register index (0..14).
rf_data  output  WIDTH  write data.
pc_load  output  1  one-cycle strobe: load PC with pc_value.
pc_value  output  WIDTH  word loaded for R15.
busy  output  1  high in every state except IDLE; pipeline stall.
done  output  1  one-cycle pulse at transfer end.
wb_addr  output  WIDTH  final base value (base +/- 4*N), valid when done is high, held until the next start.

Behaviour:
- Reset (reset==0 at a rising edge): state IDLE; all outputs 0; remaining list cleared. Reset mid-transfer aborts immediately: no further register writes, no further requests, and any later mem_rsp_valid is ignored.
- N = popcount(reg_list). Register order is always ascending index. Start address: up=1 -> base_addr; up=0 -> base_addr - 4*N. Each subsequent word is at address +4. wb_addr = base_addr + 4*N when up=1, base_addr - 4*N when up=0. All arithmetic is modulo 2^WIDTH, so wrap-around is permitted.
- FSM states: IDLE, REQ, WAIT, WRITE, DONE.
- IDLE: when start=1, latch the inputs. Next state is REQ if N>0, else DONE.
- REQ: mem_req_valid=1. mem_addr holds the current address for the register given by the lowest set bit of the remaining list. mem_addr stays stable until mem_req_ready=1 at an edge, then the state moves to WAIT.
- WAIT: mem_req_valid=0. When mem_rsp_valid=1, capture mem_rsp_data, clear the current bit, and move to WRITE. mem_rsp_valid in any other state is ignored. The memory responds no earlier than the cycle after the request is accepted.
- WRITE, one cycle:
  - For index 0..14: rf_write_enable=1, rf_dest_select=index, rf_data=captured word.
  - For index 15: pc_load=1, pc_value=captured word, rf_write_enable=0.
  - Next state is REQ if the remaining list is nonzero, else DONE.
- DONE: done=1 for one cycle, then IDLE. busy is 0 only in IDLE.
- start while not in IDLE is ignored.
- Latency per word with zero-wait memory: 3 cycles (REQ, WAIT, WRITE).
- Empty list: start at cycle 0 gives done at cycle 1, with no requests and no writes.
- rf_write_enable and pc_load are never high together. Each is high for exactly one cycle per corresponding word.

Decomposition:
- Shared package: FSM state encoding, REG_PC constant = 4'd15, WORD_BYTES constant = 4.
- One sub-module: reg_list_priority_encoder. It is combinational: 16-bit list in, 4-bit lowest set index out, plus a nonzero flag. Popcount stays inline in the top module.

Test Plan:
- reg_list=16'h0013, base=0x100, up=1, ready and response immediate -> requests at 0x100, 0x104, 0x108; writes to R0, R1, R4 with the returned data; wb_addr=0x10C; done 10 cycles after start.
- reg_list=16'h8002, base=0x200, up=0 -> requests at 0x1F8 and 0x1FC; R1 written with the first word; second word appears on pc_value with pc_load=1 and rf_write_enable=0; wb_addr=0x1F8.
- reg_list=0 -> done at cycle 1, busy high for 1 cycle, no mem_req_valid.
- mem_req_ready held low for 5 cycles and the response delayed 3 cycles -> mem_addr stable while valid; exactly one write per word; start pulses while busy are ignored.
- Reset asserted while in WAIT, then mem_rsp_valid=1 -> no write, all outputs 0, state IDLE; a fresh start works normally.
- reg_list=16'hFFFF, base=0xFFFFFFF8, up=1 -> addresses wrap to 0x0 after 0xFFFFFFFC; 15 rf writes and 1 pc_load; wb_addr=0x38.
